// File: rtl/decode_scoreboard.sv
// Decode-to-execute issue scoreboard: per-register pending-write bits, in-flight writer
// window, fence stall and post-flush drain. Optional macro: DECODE_SCOREBOARD_WB_BYPASS_EN.
module decode_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    localparam int IW = $clog2(NUM_REGS),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dec_valid_i,
    output logic                dec_ready_o,
    input  logic [IW-1:0]       dec_rs1_i,
    input  logic [IW-1:0]       dec_rs2_i,
    input  logic [IW-1:0]       dec_rd_i,
    input  logic                dec_use_rs1_i,
    input  logic                dec_use_rs2_i,
    input  logic                dec_we_i,
    input  logic                dec_fence_i,
    output logic                iss_valid_o,
    input  logic                iss_ready_i,
    input  logic                wb_valid_i,
    input  logic [IW-1:0]       wb_rd_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CW-1:0]       inflight_o,
    output logic                draining_o
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    localparam logic [CW-1:0]       MAX_CNT = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]       CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0] ONE_HOT = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]       X0      = {IW{1'b0}};

    state_t              state_r, state_n;
    logic [NUM_REGS-1:0] pend_r, pend_n, set_vec, clr_vec, haz_pend;
    logic [CW-1:0]       inflight_r, inflight_n, haz_cnt;
    logic                counted, hazard, issue, wb_retire;

    // Hazard detection against registered (or, with bypass, retiring-adjusted) state
    always_comb begin
        wb_retire = wb_valid_i && (wb_rd_i != X0) && pend_r[wb_rd_i];
        clr_vec   = wb_retire ? (ONE_HOT << wb_rd_i) : {NUM_REGS{1'b0}};
`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
        haz_pend  = pend_r & ~clr_vec;
        haz_cnt   = wb_retire ? (inflight_r - CNT_ONE) : inflight_r;
`else
        haz_pend  = pend_r;
        haz_cnt   = inflight_r;
`endif
        counted   = dec_we_i && (dec_rd_i != X0);
        hazard    = (dec_use_rs1_i && (dec_rs1_i != X0) && haz_pend[dec_rs1_i])
                 || (dec_use_rs2_i && (dec_rs2_i != X0) && haz_pend[dec_rs2_i])
                 || (counted && haz_pend[dec_rd_i])
                 || (counted && (haz_cnt == MAX_CNT))
                 || (dec_fence_i && (inflight_r != {CW{1'b0}}));
    end

    // Handshake outputs; valid deliberately ignores iss_ready_i
    always_comb begin
        iss_valid_o = 1'b0;
        dec_ready_o = 1'b0;
        case (state_r)
            ST_RUN: begin
                iss_valid_o = dec_valid_i && !hazard && !flush_i;
                dec_ready_o = dec_valid_i && iss_ready_i && !hazard && !flush_i;
            end
            ST_DRAIN: begin
                iss_valid_o = 1'b0;
                dec_ready_o = 1'b0;
            end
            default: begin
                iss_valid_o = 1'b0;
                dec_ready_o = 1'b0;
            end
        endcase
        issue = dec_valid_i && dec_ready_o;
    end

    // Pending vector and counter next state; a same-register set beats the clear
    always_comb begin
        set_vec = (issue && counted) ? (ONE_HOT << dec_rd_i) : {NUM_REGS{1'b0}};
        pend_n  = (pend_r & ~clr_vec) | set_vec;
        case ({issue && counted, wb_retire})
            2'b10:   inflight_n = inflight_r + CNT_ONE;
            2'b01:   inflight_n = inflight_r - CNT_ONE;
            default: inflight_n = inflight_r;
        endcase
    end

    // RUN/DRAIN transitions; drain ends once the counter is headed to zero
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_i) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!flush_i && (inflight_n == {CW{1'b0}})) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_RUN;
            pend_r     <= {NUM_REGS{1'b0}};
            inflight_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_n;
            pend_r     <= pend_n;
            inflight_r <= inflight_n;
        end
    end

    assign pending_o  = pend_r;
    assign inflight_o = inflight_r;
    assign draining_o = (state_r == ST_DRAIN);

    decode_scoreboard_chk #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .pend       (pend_r),
        .inflight   (inflight_r)
    );

endmodule

// Protocol and invariant checks for decode_scoreboard.
module decode_scoreboard_chk #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    localparam int IW = $clog2(NUM_REGS),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input logic                clk_i,
    input logic                rst_i,
    input logic                wb_valid_i,
    input logic [IW-1:0]       wb_rd_i,
    input logic [NUM_REGS-1:0] pend,
    input logic [CW-1:0]       inflight
);

    a_wb_pending: assert property (@(posedge clk_i) disable iff (rst_i)
        (wb_valid_i && (wb_rd_i != {IW{1'b0}})) |-> pend[wb_rd_i])
        else $error("stray writeback to x%0d", wb_rd_i);

    a_window: assert property (@(posedge clk_i) disable iff (rst_i)
        inflight <= CW'(MAX_INFLIGHT))
        else $error("in-flight window exceeded: %0d", inflight);

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard: the driver queues hand-computed expectations per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst, dec_valid, dec_ready, u1, u2, we, fence, iss_valid, iss_ready;
    logic        wbv, flush, draining;
    logic [4:0]  rs1, rs2, rd, wbrd;
    logic [31:0] pending;
    logic [2:0]  inflight;

    typedef struct {
        int          id;
        logic        iv;
        logic        dr;
        logic [31:0] p;
        logic [2:0]  inf;
        logic        dn;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   vid   = 0;

    always #5 clk = ~clk;

    decode_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dec_valid_i   (dec_valid),
        .dec_ready_o   (dec_ready),
        .dec_rs1_i     (rs1),
        .dec_rs2_i     (rs2),
        .dec_rd_i      (rd),
        .dec_use_rs1_i (u1),
        .dec_use_rs2_i (u2),
        .dec_we_i      (we),
        .dec_fence_i   (fence),
        .iss_valid_o   (iss_valid),
        .iss_ready_i   (iss_ready),
        .wb_valid_i    (wbv),
        .wb_rd_i       (wbrd),
        .flush_i       (flush),
        .pending_o     (pending),
        .inflight_o    (inflight),
        .draining_o    (draining)
    );

    task automatic idle();
        dec_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; we = 1'b0; fence = 1'b0; iss_ready = 1'b1;
        wbv = 1'b0; wbrd = 5'd0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic dec(input int a, input logic ua, input int b, input logic ub,
                       input int d, input logic w, input logic f);
        dec_valid = 1'b1;
        rs1 = 5'(a); u1 = ua; rs2 = 5'(b); u2 = ub; rd = 5'(d); we = w; fence = f;
    endtask

    task automatic wb(input int r);
        wbv = 1'b1; wbrd = 5'(r);
    endtask

    // Expected values are the DUT state and handshake during the current cycle
    task automatic cyc(input logic iv, input logic dr, input logic [31:0] p,
                       input int inf, input logic dn);
        exp_t e;
        e.id = vid; e.iv = iv; e.dr = dr; e.p = p; e.inf = 3'(inf); e.dn = dn;
        q.push_back(e);
        vid++;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string nm, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL v%0d %s got %h expected %h", id, nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("iss_valid", e.id, {31'd0, iss_valid}, {31'd0, e.iv});
            chk("dec_ready", e.id, {31'd0, dec_ready}, {31'd0, e.dr});
            chk("pending",   e.id, pending, e.p);
            chk("inflight",  e.id, {29'd0, inflight}, {29'd0, e.inf});
            chk("draining",  e.id, {31'd0, draining}, {31'd0, e.dn});
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        idle();
        // reset state and RAW on x5
        cyc(1'b0, 1'b0, 32'h0, 0, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        dec(5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);               cyc(1'b0, 1'b0, 32'h20, 1, 1'b0);
        dec(5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0); wb(5);
`ifdef DECODE_SCOREBOARD_WB_BYPASS_EN
        cyc(1'b1, 1'b1, 32'h20, 1, 1'b0);
`else
        cyc(1'b0, 1'b0, 32'h20, 1, 1'b0);
`endif
        dec(5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);               cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        // fill the window with x1..x4
        dec(0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h2, 1, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h6, 2, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'hE, 3, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0);               cyc(1'b0, 1'b0, 32'h1E, 4, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h1E, 4, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 9, 1'b0, 1'b0);               cyc(1'b1, 1'b1, 32'h1E, 4, 1'b0);
        // same-cycle issue x7 and writeback x3
        wb(4);                                              cyc(1'b0, 1'b0, 32'h1E, 4, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0); wb(3);        cyc(1'b1, 1'b1, 32'hE, 3, 1'b0);
        cyc(1'b0, 1'b0, 32'h86, 3, 1'b0);
        // fence waits for an empty back-end
        wb(1);                                              cyc(1'b0, 1'b0, 32'h86, 3, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1); wb(2);        cyc(1'b0, 1'b0, 32'h84, 2, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1); wb(7);        cyc(1'b0, 1'b0, 32'h80, 1, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);               cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        // flush with two writers outstanding
        dec(0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b0);              cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b0);              cyc(1'b1, 1'b1, 32'h400, 1, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b0); flush = 1'b1; cyc(1'b0, 1'b0, 32'hC00, 2, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b0); wb(10);      cyc(1'b0, 1'b0, 32'hC00, 2, 1'b1);
        dec(0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b0); wb(11);      cyc(1'b0, 1'b0, 32'h800, 1, 1'b1);
        dec(0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b0);              cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        // reset while draining with a pending bit
        flush = 1'b1;                                       cyc(1'b0, 1'b0, 32'h1000, 1, 1'b0);
        rst = 1'b1;                                         cyc(1'b0, 1'b0, 32'h1000, 1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 0, 1'b0);
        // flush with nothing in flight drains for one cycle
        flush = 1'b1;                                       cyc(1'b0, 1'b0, 32'h0, 0, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 13, 1'b1, 1'b0);              cyc(1'b0, 1'b0, 32'h0, 0, 1'b1);
        dec(0, 1'b0, 0, 1'b0, 13, 1'b1, 1'b0);              cyc(1'b1, 1'b1, 32'h0, 0, 1'b0);
        // x0 writer, back-pressure, rs2 and WAW hazards
        dec(0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);               cyc(1'b1, 1'b1, 32'h2000, 1, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 14, 1'b1, 1'b0); iss_ready = 1'b0; cyc(1'b1, 1'b0, 32'h2000, 1, 1'b0);
        dec(0, 1'b0, 13, 1'b1, 0, 1'b0, 1'b0);              cyc(1'b0, 1'b0, 32'h2000, 1, 1'b0);
        dec(13, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);              cyc(1'b1, 1'b1, 32'h2000, 1, 1'b0);
        dec(0, 1'b0, 0, 1'b0, 13, 1'b1, 1'b0);              cyc(1'b0, 1'b0, 32'h2000, 1, 1'b0);
        wb(13);                                             cyc(1'b0, 1'b0, 32'h2000, 1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 0, 1'b0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_queue got %0d entries left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
